// File: rtl/pc_redirect_ctrl_if.sv
// Fetch/execute handshake bundle between the pipeline and the PC redirect controller.
// master is the pipeline side, slave is the controller.
interface pc_redirect_ctrl_if;
   logic        fetch_ready;
   logic        imem_busy;
   logic        imem_resp;
   logic        bp_taken;
   logic        ex_valid;
   logic        ex_br;
   logic        ex_jal;
   logic        ex_jalr;
   logic        ex_br_en;
   logic        ex_pred_taken;
   logic [2:0]  pcmux_sel;
   logic        pc_load;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        ex_stall;
   logic        squash_resp;
   logic [31:0] redirect_cnt;
   logic [31:0] mispredict_cnt;

   modport master (
      output fetch_ready, imem_busy, imem_resp, bp_taken,
             ex_valid, ex_br, ex_jal, ex_jalr, ex_br_en, ex_pred_taken,
      input  pcmux_sel, pc_load, flush_if_id, flush_id_ex, ex_stall,
             squash_resp, redirect_cnt, mispredict_cnt
   );

   modport slave (
      input  fetch_ready, imem_busy, imem_resp, bp_taken,
             ex_valid, ex_br, ex_jal, ex_jalr, ex_br_en, ex_pred_taken,
      output pcmux_sel, pc_load, flush_if_id, flush_id_ex, ex_stall,
             squash_resp, redirect_cnt, mispredict_cnt
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: picks next-PC source, flushes younger stages on redirect, zero-latency when fetch is ready.
// A redirect that meets fetch_ready=0 is parked in HOLD (execute stalled); one stale imem response is squashed afterwards.
module pc_redirect_ctrl (
   input logic              clk,
   input logic              rst,
   pc_redirect_ctrl_if.slave bus
);
   localparam logic [2:0] SEL_PC4   = 3'b000;
   localparam logic [2:0] SEL_ALU   = 3'b001;
   localparam logic [2:0] SEL_MOD2  = 3'b010;
   localparam logic [2:0] SEL_BRP   = 3'b011;
   localparam logic [2:0] SEL_RECOV = 3'b100;

   typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_SQUASH} state_t;

   state_t      state_q, state_d;
   logic [2:0]  pend_sel_q;
   logic        pend_mis_q;
   logic [31:0] red_cnt_q, mis_cnt_q;

   logic        dec_redir, dec_mis;
   logic [2:0]  dec_sel;
   logic        cnt_bump, mis_bump;
   logic        pend_set, pend_clr;

   always_comb begin
      dec_redir = 1'b0;
      dec_mis   = 1'b0;
      dec_sel   = SEL_PC4;
      if (bus.ex_valid) begin
         if (bus.ex_jalr) begin
            dec_redir = 1'b1;
            dec_sel   = SEL_MOD2;
         end else if (bus.ex_br && bus.ex_br_en && !bus.ex_pred_taken) begin
            dec_redir = 1'b1;
            dec_mis   = 1'b1;
            dec_sel   = SEL_ALU;
         end else if (bus.ex_br && !bus.ex_br_en && bus.ex_pred_taken) begin
            dec_redir = 1'b1;
            dec_mis   = 1'b1;
            dec_sel   = SEL_RECOV;
         end else if (bus.ex_jal && !bus.ex_pred_taken) begin
            dec_redir = 1'b1;
            dec_sel   = SEL_ALU;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_RUN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (dec_redir) begin
               if (!bus.fetch_ready)   state_d = ST_HOLD;
               else if (bus.imem_busy) state_d = ST_SQUASH;
            end
         end
         ST_HOLD: begin
            if (bus.fetch_ready) state_d = bus.imem_busy ? ST_SQUASH : ST_RUN;
         end
         ST_SQUASH: begin
            if (bus.imem_resp) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Outputs are forced to their reset values whenever rst is low, not just after the edge.
   always_comb begin
      bus.pcmux_sel   = SEL_PC4;
      bus.pc_load     = 1'b0;
      bus.flush_if_id = 1'b0;
      bus.flush_id_ex = 1'b0;
      bus.ex_stall    = 1'b0;
      bus.squash_resp = 1'b0;
      cnt_bump        = 1'b0;
      mis_bump        = 1'b0;
      pend_set        = 1'b0;
      pend_clr        = 1'b0;
      if (rst) begin
         case (state_q)
            ST_RUN: begin
               bus.pcmux_sel = dec_redir ? dec_sel : (bus.bp_taken ? SEL_BRP : SEL_PC4);
               bus.pc_load   = bus.fetch_ready;
               if (dec_redir) begin
                  bus.flush_if_id = 1'b1;
                  bus.flush_id_ex = 1'b1;
                  bus.ex_stall    = !bus.fetch_ready;
                  cnt_bump        = bus.fetch_ready;
                  mis_bump        = bus.fetch_ready && dec_mis;
                  pend_set        = !bus.fetch_ready;
               end
            end
            ST_HOLD: begin
               bus.pcmux_sel = pend_sel_q;
               bus.pc_load   = bus.fetch_ready;
               bus.ex_stall  = 1'b1;
               cnt_bump      = bus.fetch_ready;
               mis_bump      = bus.fetch_ready && pend_mis_q;
               pend_clr      = bus.fetch_ready;
            end
            ST_SQUASH: begin
               bus.squash_resp = bus.imem_resp;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_sel_q <= SEL_PC4;
         pend_mis_q <= 1'b0;
         red_cnt_q  <= 32'd0;
         mis_cnt_q  <= 32'd0;
      end else begin
         if (pend_set) begin
            pend_sel_q <= dec_sel;
            pend_mis_q <= dec_mis;
         end else if (pend_clr) begin
            pend_sel_q <= SEL_PC4;
            pend_mis_q <= 1'b0;
         end
         if (cnt_bump) red_cnt_q <= red_cnt_q + 32'd1;
         if (mis_bump) mis_cnt_q <= mis_cnt_q + 32'd1;
      end
   end

   assign bus.redirect_cnt   = rst ? red_cnt_q : 32'd0;
   assign bus.mispredict_cnt = rst ? mis_cnt_q : 32'd0;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed-vector bench for pc_redirect_ctrl; expected values are hand-computed per step.
module tb_pc_redirect_ctrl;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   pc_redirect_ctrl_if bus ();

   pc_redirect_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic fr, input logic busy, input logic resp, input logic bp,
                        input logic v, input logic br, input logic jal, input logic jalr,
                        input logic en, input logic pt);
      bus.fetch_ready   = fr;
      bus.imem_busy     = busy;
      bus.imem_resp     = resp;
      bus.bp_taken      = bp;
      bus.ex_valid      = v;
      bus.ex_br         = br;
      bus.ex_jal        = jal;
      bus.ex_jalr       = jalr;
      bus.ex_br_en      = en;
      bus.ex_pred_taken = pt;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [2:0] sel, input logic ld,
                          input logic fl, input logic st, input logic sq);
      chk({tag, ".sel"},   {29'd0, bus.pcmux_sel}, {29'd0, sel});
      chk({tag, ".load"},  {31'd0, bus.pc_load}, {31'd0, ld});
      chk({tag, ".fl_if"}, {31'd0, bus.flush_if_id}, {31'd0, fl});
      chk({tag, ".fl_id"}, {31'd0, bus.flush_id_ex}, {31'd0, fl});
      chk({tag, ".stall"}, {31'd0, bus.ex_stall}, {31'd0, st});
      chk({tag, ".sq"},    {31'd0, bus.squash_resp}, {31'd0, sq});
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] red, input logic [31:0] mis);
      chk({tag, ".rcnt"}, bus.redirect_cnt, red);
      chk({tag, ".mcnt"}, bus.mispredict_cnt, mis);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;

      // reset held two edges with every input high
      rst = 1'b0;
      drive(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
      #2;
      chk_out("rst0", 3'b000, 0, 0, 0, 0);
      chk_cnt("rst0", 0, 0);
      cyc();
      chk_out("rst1", 3'b000, 0, 0, 0, 0);
      chk_cnt("rst1", 0, 0);
      cyc();
      rst = 1'b1;

      // sequential / predicted fetch
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, i[0], 0, 0, 0, 0, 0, 0);
         #1;
         chk_out("seq", i[0] ? 3'b011 : 3'b000, 1, 0, 0, 0);
         cyc();
         chk_cnt("seq", 0, 0);
      end

      // taken mispredict, fetch ready
      drive(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
      #1;
      chk_out("tmis", 3'b001, 1, 1, 0, 0);
      cyc();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_cnt("tmis", 1, 1);
      chk_out("tmis_after", 3'b000, 1, 0, 0, 0);

      // stalled not-taken mispredict: cycle 0
      drive(0, 1, 0, 1, 1, 1, 0, 0, 0, 1);
      #1;
      chk_out("stl0", 3'b100, 0, 1, 1, 0);
      cyc();
      // cycles 1,2: ex inputs now ask for a JALR, must be ignored
      for (int i = 1; i < 3; i++) begin
         drive(0, 1, 0, 1, 1, 0, 0, 1, 0, 0);
         #1;
         chk_out("stl_hold", 3'b100, 0, 0, 1, 0);
         chk_cnt("stl_hold", 1, 1);
         cyc();
      end
      drive(1, 1, 0, 1, 1, 0, 0, 1, 0, 0);
      #1;
      chk_out("stl3", 3'b100, 1, 0, 1, 0);
      cyc();
      drive(1, 1, 0, 1, 1, 0, 0, 1, 0, 0);
      #1;
      chk_out("sqw", 3'b000, 0, 0, 0, 0);
      chk_cnt("sqw", 2, 2);
      cyc();
      drive(1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
      #1;
      chk_out("sqr", 3'b000, 0, 0, 0, 1);
      cyc();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_out("sq_done", 3'b000, 1, 0, 0, 0);
      chk_cnt("sq_done", 2, 2);
      cyc();

      // JALR outranks a taken mispredict
      drive(1, 0, 0, 1, 1, 1, 0, 1, 1, 0);
      #1;
      chk_out("prio", 3'b010, 1, 1, 0, 0);
      cyc();
      // unpredicted JAL with bp_taken: redirect wins, not a mispredict
      drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      #1;
      chk_cnt("prio", 3, 2);
      chk_out("jal", 3'b001, 1, 1, 0, 0);
      cyc();
      // predicted JAL: no redirect, predictor path
      drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 1);
      #1;
      chk_cnt("jal", 4, 2);
      chk_out("jal_pred", 3'b011, 1, 0, 0, 0);
      cyc();
      chk_cnt("jal_pred", 4, 2);

      // response coinciding with the entry into SQUASH is not squashed
      drive(1, 1, 1, 0, 1, 1, 0, 0, 1, 0);
      #1;
      chk_out("sq_entry", 3'b001, 1, 1, 0, 0);
      cyc();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_out("sq_next", 3'b000, 0, 0, 0, 1);
      chk_cnt("sq_next", 5, 3);
      cyc();

      // counter wrap
      force dut.red_cnt_q = 32'hFFFF_FFFF;
      force dut.mis_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.red_cnt_q;
      release dut.mis_cnt_q;
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
      #1;
      chk_out("wrap", 3'b100, 1, 1, 0, 0);
      cyc();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_cnt("wrap", 0, 0);
      // one more redirect so the later reset has something to clear
      drive(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      cyc();
      chk_cnt("pre_hold", 1, 0);

      // reset while in HOLD
      drive(0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
      #1;
      chk_out("hold_in", 3'b001, 0, 1, 1, 0);
      cyc();
      rst = 1'b0;
      drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      #1;
      chk_out("hold_rst", 3'b000, 0, 0, 0, 0);
      chk_cnt("hold_rst", 0, 0);
      cyc();
      rst = 1'b1;
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_out("post_rst", 3'b000, 1, 0, 0, 0);
      chk_cnt("post_rst", 0, 0);
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
